mem_port_ctrl: RTL and testbench
================================

MEM_PORT_CTRL -- requirements
Module: mem_port_ctrl

Interface
REQ-001 Parameter: DATA_W, 8, memory word width.
REQ-002 Parameter: ADDR_W, 3, memory address width (8 words).
REQ-003 Parameter: FIFO_DEPTH, 4, command FIFO entries (power of two, >=2).
REQ-004 clock  input  1  sole clock; all state updates on its rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 cmd_valid  input  1  command offered.
REQ-007 cmd_ready  output  1  command FIFO can accept.
REQ-008 cmd_we  input  1  1 = write, 0 = read.
REQ-009 cmd_addr  input  ADDR_W  target word.
REQ-010 cmd_wdata  input  DATA_W  write data (ignored for reads).
REQ-011 rsp_valid  output  1  read response held.
REQ-012 rsp_ready  input  1  consumer takes response.
REQ-013 rsp_data / rsp_addr  output  DATA_W / ADDR_W  read data and its address.
REQ-014 write, read  output  1 each  memory write / read strobes.
REQ-015 addr_w, addr_r  output  ADDR_W  memory write / read addresses.
REQ-016 datain  output  DATA_W  memory write data.
REQ-017 dataout  input  DATA_W  memory read data, valid one cycle after read=1.
REQ-018 busy  output  1  FIFO non-empty or FSM not IDLE.

Function
REQ-019 Command accepted on a clock edge with cmd_valid && cmd_ready; pushed into FIFO in arrival order.
REQ-020 cmd_ready SHALL equal !full, independent of cmd_valid and of same-cycle pops (no bypass).
REQ-021 FSM states: IDLE, RD_WAIT, RSP.
REQ-022 IDLE, FIFO non-empty, head is write: pop, drive write=1, addr_w, datain for exactly that cycle; stay IDLE; back-to-back writes one per cycle.
REQ-023 IDLE, head is read: pop, drive read=1, addr_r for one cycle; go RD_WAIT.
REQ-024 RD_WAIT: read=0, no pop; capture dataout into rsp_data, addr into rsp_addr; go RSP.
REQ-025 RSP: rsp_valid=1, rsp_data/rsp_addr stable; on rsp_ready go IDLE (next command issues the following cycle); no pop while in RSP.
REQ-026 Read-to-response latency from read strobe: 2 cycles (rsp_valid asserted 2 edges after read strobe edge, min).
REQ-027 Strict FIFO ordering: a read after a write to the same address returns the written data.
REQ-028 write and read never both 1 in a cycle; strobes registered outputs, 0 when idle.
REQ-029 Full FIFO with simultaneous pop: cmd_ready stays 0 that cycle; next cycle 1.
REQ-030 FIFO pointers wrap modulo FIFO_DEPTH; count width ADDR of FIFO+1 distinguishes full/empty.

Reset
REQ-031 While reset=1: FIFO emptied, FSM to IDLE, write=read=0, rsp_valid=0, rsp_data=0, rsp_addr=0, addr_w=addr_r=0, datain=0, busy=0.
REQ-032 cmd_ready SHALL be 1 in the first cycle after reset deasserts.
REQ-033 Reset mid-read (RD_WAIT or RSP) discards pending response and all queued commands; no strobe issued afterwards.

Structure
REQ-034 Shared package mem_pkg holds DATA_W, ADDR_W defaults, command struct {we, addr, wdata}, FSM state enum.
REQ-035 One sub-module: cmd_fifo (synchronous FIFO, push/pop/full/empty), instantiated once.

Verification
REQ-036 Write 0x05 to addr 5, then read addr 5 -> write=1 with addr_w=5/datain=0x05; rsp_valid with rsp_data=0x05, rsp_addr=5.
REQ-037 Push 5 writes with cmd_valid held, memory idle-pop disabled by pending read at head -> cmd_ready=0 after 4 accepts; 5th accepted after pop.
REQ-038 Writes 0x40->3, 0x70->1, 0x04->2, then reads 0,5,2,4,1,3 with rsp_ready=1 -> responses in order, data matches model.
REQ-039 Read with rsp_ready=0 for 5 cycles -> rsp_valid/rsp_data stable, no further strobes, then release -> next command issues.
REQ-040 Assert reset during RD_WAIT with 3 queued commands -> all outputs at reset values, no strobe after reset, busy=0.
REQ-041 Back-to-back 4 writes queued -> write=1 on 4 consecutive cycles, addresses in order.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared widths, command payload and controller state encoding for mem_port_ctrl.
package mem_pkg;

    localparam int unsigned MEM_DATA_W     = 8;
    localparam int unsigned MEM_ADDR_W     = 3;
    localparam int unsigned MEM_FIFO_DEPTH = 4;

    typedef struct packed {
        logic                  we;
        logic [MEM_ADDR_W-1:0] addr;
        logic [MEM_DATA_W-1:0] wdata;
    } cmd_t;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RD_WAIT = 2'd1,
        ST_RSP     = 2'd2
    } state_t;

endpackage

// File: rtl/cmd_fifo.sv
// Synchronous command FIFO; full/empty are registered flags derived from the next occupancy.
module cmd_fifo
    import mem_pkg::*;
#(
    parameter int unsigned DEPTH = MEM_FIFO_DEPTH
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  cmd_t                     wr_cmd,
    output cmd_t                     rd_cmd,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    cmd_t             store [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count_nxt;
    logic             do_push;
    logic             do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rd_cmd  = store[rd_ptr];

    // Occupancy after this edge's push/pop.
    always_comb begin
        count_nxt = level + CNT_W'(do_push) - CNT_W'(do_pop);
    end

    // Pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            level <= count_nxt;
            full  <= (count_nxt == CNT_W'(DEPTH));
            empty <= (count_nxt == '0);
        end
    end

    // Payload storage; no reset needed, validity tracked by the pointers.
    always_ff @(posedge clock) begin
        if (do_push) store[wr_ptr] <= wr_cmd;
    end

endmodule

// File: rtl/mem_port_ctrl.sv
// Queues read/write commands and issues them to a single-port memory in order,
// holding each read response until the consumer takes it.
module mem_port_ctrl
    import mem_pkg::*;
#(
    parameter int unsigned DATA_W     = MEM_DATA_W,
    parameter int unsigned ADDR_W     = MEM_ADDR_W,
    parameter int unsigned FIFO_DEPTH = MEM_FIFO_DEPTH
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_we,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data,
    output logic [ADDR_W-1:0] rsp_addr,
    output logic              write,
    output logic              read,
    output logic [ADDR_W-1:0] addr_w,
    output logic [ADDR_W-1:0] addr_r,
    output logic [DATA_W-1:0] datain,
    input  logic [DATA_W-1:0] dataout,
    output logic              busy
);

    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;

    cmd_t             push_cmd;
    cmd_t             head;
    logic             fifo_full;
    logic             fifo_empty;
    logic [CNT_W-1:0] level;
    logic [CNT_W-1:0] level_nxt;
    logic             push;
    logic             pop;
    state_t           state;
    logic             rd_phase;

    assign cmd_ready = !fifo_full;
    assign push      = cmd_valid && !fifo_full;
    assign pop       = (state == ST_IDLE) && !fifo_empty;

    // Pack the incoming command and project the FIFO occupancy after this edge.
    always_comb begin
        push_cmd.we    = cmd_we;
        push_cmd.addr  = MEM_ADDR_W'(cmd_addr);
        push_cmd.wdata = MEM_DATA_W'(cmd_wdata);
        level_nxt      = level + CNT_W'(push) - CNT_W'(pop);
    end

    cmd_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_cmd_fifo (
        .clock  (clock),
        .reset  (reset),
        .push   (push),
        .pop    (pop),
        .wr_cmd (push_cmd),
        .rd_cmd (head),
        .full   (fifo_full),
        .empty  (fifo_empty),
        .level  (level)
    );

    // Issue FSM; strobes last one cycle, dataout lands the cycle after the read strobe.
    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= ST_IDLE;
            rd_phase  <= 1'b0;
            write     <= 1'b0;
            read      <= 1'b0;
            addr_w    <= '0;
            addr_r    <= '0;
            datain    <= '0;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            rsp_addr  <= '0;
            busy      <= 1'b0;
        end else begin
            write <= 1'b0;
            read  <= 1'b0;
            case (state)
                ST_IDLE: begin
                    busy <= (level_nxt != '0);
                    if (pop) begin
                        if (head.we) begin
                            write  <= 1'b1;
                            addr_w <= ADDR_W'(head.addr);
                            datain <= DATA_W'(head.wdata);
                        end else begin
                            read     <= 1'b1;
                            addr_r   <= ADDR_W'(head.addr);
                            rd_phase <= 1'b0;
                            state    <= ST_RD_WAIT;
                            busy     <= 1'b1;
                        end
                    end
                end
                ST_RD_WAIT: begin
                    busy <= 1'b1;
                    if (!rd_phase) begin
                        rd_phase <= 1'b1;
                    end else begin
                        rsp_data  <= dataout;
                        rsp_addr  <= addr_r;
                        rsp_valid <= 1'b1;
                        state     <= ST_RSP;
                    end
                end
                ST_RSP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= ST_IDLE;
                        busy      <= (level_nxt != '0);
                    end else begin
                        busy <= 1'b1;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_ctrl.sv
// Bench for mem_port_ctrl: behavioural memory, in-order command model, directed and random traffic.
module tb_mem_port_ctrl;

    localparam int DW    = 8;
    localparam int AW    = 3;
    localparam int DEPTH = 4;

    logic          clock;
    logic          reset;
    logic          cmd_valid;
    logic          cmd_ready;
    logic          cmd_we;
    logic [AW-1:0] cmd_addr;
    logic [DW-1:0] cmd_wdata;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [DW-1:0] rsp_data;
    logic [AW-1:0] rsp_addr;
    logic          write;
    logic          read;
    logic [AW-1:0] addr_w;
    logic [AW-1:0] addr_r;
    logic [DW-1:0] datain;
    logic [DW-1:0] dataout;
    logic          busy;

    mem_port_ctrl #(.DATA_W(DW), .ADDR_W(AW), .FIFO_DEPTH(DEPTH)) dut (
        .clock     (clock),
        .reset     (reset),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_we    (cmd_we),
        .cmd_addr  (cmd_addr),
        .cmd_wdata (cmd_wdata),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_addr  (rsp_addr),
        .write     (write),
        .read      (read),
        .addr_w    (addr_w),
        .addr_r    (addr_r),
        .datain    (datain),
        .dataout   (dataout),
        .busy      (busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Behavioural single-port memory: registered read, write on strobe.
    logic [DW-1:0] mem [8];
    always @(posedge clock) begin
        if (write) mem[addr_w] <= datain;
        if (read)  dataout <= mem[addr_r];
    end

    typedef struct { bit we; int addr; int data; } op_t;
    typedef struct { int addr; int data; } rsp_t;

    op_t  exp_q[$];
    rsp_t rsp_q[$];
    int   model_mem[8];
    int   occ;
    bit   pending;
    int   cyc;
    int   last_read_cyc;
    bit   prev_rv;
    int   wr_log[$];
    int   wr_addr_log[$];
    int   checks;
    int   errors;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Model: commands are consumed strictly in acceptance order; memory effects apply at issue.
    always @(negedge clock) begin : mon
        op_t op;
        cyc++;
        if (reset) begin
            exp_q.delete();
            rsp_q.delete();
            occ     = 0;
            pending = 0;
            prev_rv = 0;
        end else begin
            check("strobe_exclusive", write && read, 0);
            if (write || read) begin
                check("strobe_during_rsp", pending, 0);
                check("strobe_expected", exp_q.size() != 0, 1);
            end
            if (write && exp_q.size() != 0) begin
                op = exp_q.pop_front();
                occ--;
                check("write_kind", op.we, 1);
                check("write_addr", addr_w, op.addr);
                check("write_data", datain, op.data);
                model_mem[op.addr] = op.data;
                wr_log.push_back(cyc);
                wr_addr_log.push_back(int'(addr_w));
            end
            if (read && exp_q.size() != 0) begin
                op = exp_q.pop_front();
                occ--;
                check("read_kind", op.we, 0);
                check("read_addr", addr_r, op.addr);
                rsp_q.push_back('{op.addr, model_mem[op.addr]});
                pending       = 1;
                last_read_cyc = cyc;
            end
            check("cmd_ready", cmd_ready, occ < DEPTH);
            check("busy", busy, (occ != 0) || pending);
            if (rsp_valid) begin
                check("rsp_expected", rsp_q.size() != 0, 1);
                if (rsp_q.size() != 0) begin
                    check("rsp_addr", rsp_addr, rsp_q[0].addr);
                    check("rsp_data", rsp_data, rsp_q[0].data);
                    if (!prev_rv) check("rsp_latency", cyc - last_read_cyc, 2);
                    if (rsp_ready) begin
                        void'(rsp_q.pop_front());
                        pending = 0;
                    end
                end
            end else if (pending) begin
                check("rsp_late", (cyc - last_read_cyc) < 2, 1);
            end
            prev_rv = rsp_valid;
            if (cmd_valid && cmd_ready) begin
                exp_q.push_back('{cmd_we, int'(cmd_addr), int'(cmd_wdata)});
                occ++;
            end
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic send(input bit we, input int a, input int d);
        bit ok;
        ok        = 0;
        cmd_valid = 1'b1;
        cmd_we    = we;
        cmd_addr  = AW'(a);
        cmd_wdata = DW'(d);
        for (int i = 0; i < 100; i++) begin
            @(negedge clock);
            if (cmd_ready) begin
                ok = 1;
                tick();
                break;
            end
            tick();
        end
        cmd_valid = 1'b0;
        check("send_accept", ok, 1);
    endtask

    task automatic wait_idle(input int max);
        bit done;
        done = 0;
        for (int i = 0; i < max; i++) begin
            @(negedge clock);
            if (exp_q.size() == 0 && rsp_q.size() == 0 && !busy && !pending) begin
                done = 1;
                break;
            end
        end
        tick();
        check("drain", done, 1);
    endtask

    task automatic wait_rsp(input int max, output bit seen);
        seen = 0;
        for (int i = 0; i < max; i++) begin
            @(negedge clock);
            if (rsp_valid) begin
                seen = 1;
                break;
            end
        end
        check("rsp_seen", seen, 1);
    endtask

    task automatic check_reset_vals();
        check("rst_write", write, 0);
        check("rst_read", read, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_rsp_data", rsp_data, 0);
        check("rst_rsp_addr", rsp_addr, 0);
        check("rst_addr_w", addr_w, 0);
        check("rst_addr_r", addr_r, 0);
        check("rst_datain", datain, 0);
        check("rst_busy", busy, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin : main
        bit seen;
        int idx;
        int expv;
        checks    = 0;
        errors    = 0;
        cyc       = 0;
        occ       = 0;
        pending   = 0;
        prev_rv   = 0;
        reset     = 1'b1;
        cmd_valid = 1'b0;
        cmd_we    = 1'b0;
        cmd_addr  = '0;
        cmd_wdata = '0;
        rsp_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            mem[i]       = DW'($urandom);
            model_mem[i] = int'(mem[i]);
        end

        // Reset values and first-cycle readiness.
        repeat (3) tick();
        @(negedge clock);
        check_reset_vals();
        tick();
        reset = 1'b0;
        @(negedge clock);
        check("ready_after_reset", cmd_ready, 1);
        tick();

        // Write then read the same word.
        send(1, 5, 8'h05);
        send(0, 5, 0);
        wait_rsp(20, seen);
        check("wr_rd_data", rsp_data, 8'h05);
        check("wr_rd_addr", rsp_addr, 5);
        tick();
        wait_idle(50);

        // Mixed writes and reads with the consumer always ready.
        rsp_ready = 1'b1;
        send(1, 3, 8'h40);
        send(1, 1, 8'h70);
        send(1, 2, 8'h04);
        send(0, 0, 0);
        send(0, 5, 0);
        send(0, 2, 0);
        send(0, 4, 0);
        send(0, 1, 0);
        send(0, 3, 0);
        wait_idle(100);
        check("model_mem3", model_mem[3], 8'h40);

        // Stalled response: data held, nothing issued until released.
        rsp_ready = 1'b0;
        send(0, 3, 0);
        send(1, 6, 8'hAA);
        wait_rsp(20, seen);
        expv = model_mem[3];
        for (int i = 0; i < 5; i++) begin
            check("hold_valid", rsp_valid, 1);
            check("hold_data", rsp_data, expv);
            check("hold_no_write", write, 0);
            check("hold_no_read", read, 0);
            @(negedge clock);
        end
        tick();
        rsp_ready = 1'b1;
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            if (write) begin
                seen = 1;
                break;
            end
        end
        check("release_issue", seen, 1);
        check("release_addr", addr_w, 6);
        tick();
        wait_idle(50);

        // Fill the FIFO behind a stalled read, then back-to-back writes on release.
        rsp_ready = 1'b0;
        send(0, 1, 0);
        for (int i = 0; i < 4; i++) send(1, i, 8'h10 + i);
        cmd_valid = 1'b1;
        cmd_we    = 1'b1;
        cmd_addr  = 3'd7;
        cmd_wdata = 8'h99;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            check("full_ready", cmd_ready, 0);
            tick();
        end
        idx = wr_log.size();
        rsp_ready = 1'b1;
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clock);
            if (cmd_ready) begin
                seen = 1;
                tick();
                break;
            end
            tick();
        end
        cmd_valid = 1'b0;
        check("fifth_accept", seen, 1);
        wait_idle(50);
        check("b2b_count", wr_log.size() >= idx + 4, 1);
        if (wr_log.size() >= idx + 4) begin
            for (int k = 0; k < 4; k++) begin
                check("b2b_addr", wr_addr_log[idx + k], k);
                if (k > 0) check("b2b_gap", wr_log[idx + k] - wr_log[idx + k - 1], 1);
            end
        end

        // Reset while a read waits for memory data with three commands queued.
        rsp_ready = 1'b0;
        send(0, 2, 0);
        wait_rsp(20, seen);
        tick();
        send(0, 4, 0);
        send(1, 5, 8'h11);
        send(1, 6, 8'h22);
        send(1, 7, 8'h33);
        rsp_ready = 1'b1;
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            if (read) begin
                seen = 1;
                break;
            end
        end
        check("rdwait_read_seen", seen, 1);
        @(posedge clock);
        #1;
        reset = 1'b1;
        tick();
        tick();
        @(negedge clock);
        check_reset_vals();
        tick();
        reset = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            check("post_rst_write", write, 0);
            check("post_rst_read", read, 0);
            check("post_rst_busy", busy, 0);
            check("post_rst_rsp", rsp_valid, 0);
            tick();
        end

        // Random traffic against the model.
        for (int i = 0; i < 400; i++) begin
            cmd_valid = 1'($urandom_range(0, 1));
            cmd_we    = 1'($urandom_range(0, 1));
            cmd_addr  = AW'($urandom_range(0, 7));
            cmd_wdata = DW'($urandom);
            rsp_ready = ($urandom_range(0, 3) != 0);
            tick();
        end
        cmd_valid = 1'b0;
        rsp_ready = 1'b1;
        wait_idle(200);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
